// File: rtl/dff_pkg.sv
// Shared definitions for the shared-register arbiter: FSM states, default
// parameters and a one-hot helper used when building grant vectors.
package dff_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_HOLD_MAX = 4;
  localparam int MAX_REQ      = 32;

  // Callers keep only the low NREQ bits of the result.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational cyclic selector: first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  // Scanning from the farthest offset down lets the nearest hit overwrite.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      cand = sum[IDW-1:0];
      if (req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin owner of one shared WIDTH-bit register; a winner may lock the
// register for a burst of up to HOLD_MAX consecutive writes.
module dff_share_arbiter
  import dff_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        q_owner,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int CNTW = $clog2(HOLD_MAX + 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;

  logic             pickAny;
  logic [IDW-1:0]   pickIdx;
  logic [WIDTH-1:0] dataArr [NREQ];
  logic [MAX_REQ-1:0] ohWide;
  logic [CNTW-1:0]  cntInc;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign dataArr[i] = data[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pickAny),
    .idx_o (pickIdx)
  );

  assign cntInc = cnt_q + CNTW'(1);

  // In HOLD only the owner matters; ptr already points past it, so fairness
  // is restored as soon as the burst ends.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    gnt_d   = '0;
    ohWide  = '0;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          ohWide  = onehot(32'(pickIdx));
          gnt_d   = ohWide[NREQ-1:0];
          data_d  = dataArr[pickIdx];
          owner_d = pickIdx;
          valid_d = 1'b1;
          ptr_d   = (pickIdx == IDW'(NREQ - 1)) ? '0 : pickIdx + IDW'(1);
          cnt_d   = CNTW'(1);
          state_d = (lock[pickIdx] && (HOLD_MAX > 1)) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (req[owner_q]) begin
          ohWide  = onehot(32'(owner_q));
          gnt_d   = ohWide[NREQ-1:0];
          data_d  = dataArr[owner_q];
          cnt_d   = cntInc;
          state_d = (lock[owner_q] && (cntInc < CNTW'(HOLD_MAX))) ? HOLD : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_owner = owner_q;
  assign q_valid = valid_q;
  assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Self-checking bench for dff_share_arbiter: directed scenarios plus random
// traffic compared against a behavioural model of the sharing rules.
module tb_dff_share_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;
  localparam int IDW      = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        q_owner;
  logic                  q_valid;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the shared register and its arbitration rules.
  logic [WIDTH-1:0] mQ;
  int               mOwner;
  bit               mValid;
  logic [NREQ-1:0]  mGnt;
  int               mPtr;
  bit               mHold;
  int               mBurst;

  dff_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .data    (data),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mQ = '0; mOwner = 0; mValid = 0; mGnt = '0; mPtr = 0; mHold = 0; mBurst = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                            input logic [NREQ*WIDTH-1:0] d);
    int w;
    int c;
    mGnt = '0;
    w = -1;
    if (mHold) begin
      if (r[mOwner]) begin
        mQ     = d[mOwner*WIDTH +: WIDTH];
        mGnt   = NREQ'(1 << mOwner);
        mBurst = mBurst + 1;
        mHold  = l[mOwner] && (mBurst < HOLD_MAX);
      end else begin
        mHold = 0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (mPtr + k) % NREQ;
        if (w < 0 && r[c]) w = c;
      end
      if (w >= 0) begin
        mQ     = d[w*WIDTH +: WIDTH];
        mOwner = w;
        mValid = 1;
        mGnt   = NREQ'(1 << w);
        mPtr   = (w + 1) % NREQ;
        mBurst = 1;
        mHold  = l[w] && (HOLD_MAX > 1);
      end
    end
  endtask

  // Called at posedge+1; inputs change there and are sampled at the next edge.
  task automatic drive_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                            input logic [NREQ*WIDTH-1:0] d);
    req = r; lock = l; data = d;
    @(posedge clk);
    model_step(r, l, d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; lock = '0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, q_owner, q_valid, gnt, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state got q=%h own=%0d v=%b gnt=%b busy=%b want all zero",
               q, q_owner, q_valid, gnt, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_edge(4'b0010, 4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00});
    drive_edge(4'b0010, 4'b0010, {8'h00, 8'h00, 8'h5B, 8'h00});
    checks++;
    if (busy !== 1'b1 || q !== 8'h5B) begin
      errors++;
      $display("[TB] FAIL burst_before_reset got busy=%b q=%h want busy=1 q=5b", busy, q);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0 || q_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got q=%h gnt=%b busy=%b v=%b want 00 0000 0 0",
               q, gnt, busy, q_valid);
    end
    #1 rst = 1'b0;
    drive_edge(4'b0100, 4'b0000, {8'h00, 8'h77, 8'h00, 8'h00});
    checks++;
    if (q_owner !== 2'd2 || q !== 8'h77 || gnt !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL after_reset_grant got own=%0d q=%h gnt=%b want 2 77 0100",
               q_owner, q, gnt);
    end
  endtask

  task automatic test_rotation();
    logic [WIDTH-1:0] expQ [5];
    logic [NREQ-1:0]  expG [5];
    expQ = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    expG = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_edge(4'b1111, 4'b0000, {8'h13, 8'h12, 8'h11, 8'h10});
      checks++;
      if (q !== expQ[i] || gnt !== expG[i]) begin
        errors++;
        $display("[TB] FAIL rotation[%0d] got q=%h gnt=%b want q=%h gnt=%b",
                 i, q, gnt, expQ[i], expG[i]);
      end
    end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    drive_edge(4'b0100, 4'b0000, {8'h33, 8'h22, 8'h11, 8'h00});
    drive_edge(4'b0011, 4'b0000, {8'h33, 8'h22, 8'h11, 8'h00});
    checks++;
    if (q_owner !== 2'd0 || q !== 8'h00 || gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL skip_wrap_first got own=%0d q=%h gnt=%b want 0 00 0001",
               q_owner, q, gnt);
    end
    drive_edge(4'b0011, 4'b0000, {8'h33, 8'h22, 8'h11, 8'h00});
    checks++;
    if (q_owner !== 2'd1 || q !== 8'h11 || gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL skip_wrap_second got own=%0d q=%h gnt=%b want 1 11 0010",
               q_owner, q, gnt);
    end
  endtask

  task automatic test_locked_burst();
    logic [NREQ*WIDTH-1:0] d;
    do_reset();
    for (int i = 1; i <= HOLD_MAX; i++) begin
      d = {$urandom, $urandom} >> 32;
      drive_edge(4'b0011, 4'b0001, d);
      checks++;
      if (gnt !== 4'b0001 || q !== d[7:0] || busy !== (i < HOLD_MAX)) begin
        errors++;
        $display("[TB] FAIL locked_burst[%0d] got gnt=%b q=%h busy=%b want 0001 %h %b",
                 i, gnt, q, busy, d[7:0], (i < HOLD_MAX));
      end
    end
    d = 32'hC3B2A190;
    drive_edge(4'b0011, 4'b0001, d);
    checks++;
    if (gnt !== 4'b0010 || q !== 8'hA1 || q_owner !== 2'd1) begin
      errors++;
      $display("[TB] FAIL burst_handoff got gnt=%b q=%h own=%0d want 0010 a1 1",
               gnt, q, q_owner);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    drive_edge(4'b0100, 4'b0100, {8'h44, 8'h3C, 8'h00, 8'h00});
    checks++;
    if (busy !== 1'b1 || q !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL early_lock got busy=%b q=%h want 1 3c", busy, q);
    end
    drive_edge(4'b1011, 4'b0000, {8'h99, 8'h88, 8'h77, 8'h66});
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h3C || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL early_drop got gnt=%b q=%h busy=%b want 0000 3c 0", gnt, q, busy);
    end
    drive_edge(4'b1011, 4'b0000, {8'h99, 8'h88, 8'h77, 8'h66});
    checks++;
    if (gnt !== 4'b1000 || q_owner !== 2'd3 || q !== 8'h99) begin
      errors++;
      $display("[TB] FAIL early_next got gnt=%b own=%0d q=%h want 1000 3 99",
               gnt, q_owner, q);
    end
  endtask

  task automatic test_idle_hold();
    do_reset();
    drive_edge(4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'hA5});
    for (int i = 0; i < 10; i++) begin
      drive_edge(4'b0000, 4'b1111, 32'($urandom));
      checks++;
      if (q !== 8'hA5 || q_valid !== 1'b1 || gnt !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL idle_hold[%0d] got q=%h v=%b gnt=%b want a5 1 0000",
                 i, q, q_valid, gnt);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] l;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = NREQ'($urandom);
      l = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      drive_edge(r, l, 32'($urandom));
      checks++;
      if (q !== mQ || q_owner !== IDW'(mOwner) || q_valid !== mValid ||
          gnt !== mGnt || busy !== mHold) begin
        errors++;
        $display("[TB] FAIL random[%0d] got q=%h own=%0d v=%b gnt=%b busy=%b want %h %0d %b %b %b",
                 i, q, q_owner, q_valid, gnt, busy, mQ, mOwner, mValid, mGnt, mHold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_rotation();
    test_skip_wrap();
    test_locked_burst();
    test_early_release();
    test_idle_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dff_share_arbiter.md
# dff_share_arbiter

Round-robin arbiter that shares one WIDTH-bit D-flip-flop register among NREQ requesters. Each cycle it picks at most one requester and loads that requester's data into the shared register. A requester may lock the register for a bounded burst of consecutive writes. The block sits between requester logic and the shared storage register in the dff datapath, and owns both the register and its write sequencing.

## Interface
- NREQ, 4, number of requesters (≥1)
- WIDTH, 8, shared register width
- HOLD_MAX, 4, max consecutive writes per locked burst (≥1)
- IDW, $clog2(NREQ) (min 1), owner-id width (derived)

- clk  in  1  rising-edge clock; the block uses one clock only
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  write request per requester
- lock  in  NREQ  burst-lock request; only meaningful alongside req
- data  in  NREQ*WIDTH  requester i's data at data[i*WIDTH +: WIDTH]
- gnt  out  NREQ  registered one-hot write acknowledge
- q  out  WIDTH  shared register contents
- q_owner  out  IDW  index of the last writer
- q_valid  out  1  high once q has been written since reset
- busy  out  1  high while in HOLD

## Operation
- State: IDLE, HOLD. Internal: ptr (IDW bits), owner (IDW bits), cnt (range 0..HOLD_MAX).
- IDLE, at each edge with any req bit high:
  - winner w = first index ≥ ptr with req high, searching cyclically through NREQ-1 and wrapping to 0.
  - q←data[w], q_owner←w, q_valid←1, gnt←onehot(w), ptr←(w+1) mod NREQ, owner←w, cnt←1.
  - Next state is HOLD if lock[w]=1 and HOLD_MAX>1; otherwise IDLE.
- IDLE with no req: gnt←0. q, q_owner, ptr and q_valid hold.
- HOLD: only owner is considered; all other req bits are ignored.
  - If req[owner]=1: q←data[owner], gnt←onehot(owner), cnt←cnt+1. Stay in HOLD if lock[owner]=1 and cnt+1<HOLD_MAX; otherwise go to IDLE.
  - If req[owner]=0: gnt←0, no write, go to IDLE.
- ptr does not change in HOLD. Fairness is preserved because ptr already points past owner.
- On return to IDLE, the next edge arbitrates normally. The previous owner may win again only if no requester between ptr and owner is requesting.
- lock without req is ignored.
- NREQ=1: ptr stays 0, and a single requester is always granted.

## Timing
- Reset values while rst=1: q=0, q_owner=0, q_valid=0, gnt=0, busy=0, state=IDLE, ptr=0, owner=0, cnt=0. This takes effect immediately, including mid-burst.
- First edge after rst falls behaves as an IDLE arbitration.
- Latency: req/data sampled at edge k → q, q_owner and gnt updated after edge k, i.e. visible in cycle k+1. One write per cycle at most.
- gnt[i]=1 in cycle k+1 means data[i] sampled at edge k is now in q. A requester drops req in cycle k+1 if it has nothing more to write.
- Burst length: at most HOLD_MAX consecutive writes by one owner. The first write is the IDLE grant.
- busy is registered: high in the cycles after an edge that enters or stays in HOLD.
- Arbitration never blocks. With any req high in IDLE, a write occurs at that edge.

## Structure
- Shared package dff_pkg holds:
  - state enum (IDLE, HOLD)
  - helper function for onehot(idx)
  - default parameter constants
- Sub-module rr_pick: combinational cyclic first-set-from-ptr selector. Inputs req[NREQ] and ptr; outputs any and idx[IDW]. It is reusable by other shared-resource controllers.
- Top holds the FSM, the counter, ptr, and the q/q_owner/q_valid/gnt registers.

## Test plan
- Reset mid-burst: requester 1 locked with cnt=2, assert rst between edges → q=0, gnt=0, busy=0, q_valid=0 immediately. After release, req=4'b0100 → q_owner=2.
- Rotation: req=4'b1111 held, data[i]=8'h10+i, lock=0 → q sequence 10,11,12,13,10 and gnt 0001,0010,0100,1000,0001 on successive cycles.
- Skip/wrap: ptr=3 after a grant to 2, req=4'b0011 → winner 0, then ptr=1 → next winner 1.
- Locked burst (HOLD_MAX=4): req=4'b0011, lock[0]=1 held → owner 0 gets 4 consecutive grants, busy high for cycles 2–4. The 5th edge grants requester 1.
- Early release: owner 2 in HOLD drops req[2] → gnt=0 and q unchanged that cycle, then IDLE. The next edge grants the next requester after 2.
- Idle hold: after q=8'hA5, req=0 for 10 cycles → q=8'hA5, q_valid=1, gnt=0 throughout.
